// File: rtl/pc_fetch_if.sv
// pc_fetch_if: redirect, instruction-memory and decode-side signals of the
// fetch stage. The fetch unit connects through the master modport; the
// memory/decode/branch side connects through the slave modport.
interface pc_fetch_if;
    logic        branch;
    logic [9:0]  targetAddress;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [9:0]  inst_pc;
    logic        inst_ready;

    modport master (
        input  branch, targetAddress, imem_ack, imem_data, inst_ready,
        output imem_req, imem_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output branch, targetAddress, imem_ack, imem_data, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: single-entry instruction fetch stage. Requests the word at pc,
// buffers the returned word until decode takes it, and redirects on branch.
// Optional feature: define FETCH_REDIRECT_CNT_EN to add an 8-bit saturating
// redirect_cnt output that counts branch cycles.
module pc_fetch #(
    parameter logic [9:0] RESET_PC = 10'h000
) (
    input  logic          clk,
    input  logic          rst,
    pc_fetch_if.master    fetch
`ifdef FETCH_REDIRECT_CNT_EN
    ,
    output logic [7:0]    redirect_cnt
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [9:0]  pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [9:0]  inst_pc_q, inst_pc_d;

    logic        ack_take;
    logic        transfer;

    // A response is only captured in FETCH and only if no redirect kills it.
    assign ack_take = (state_q == FETCH) && fetch.imem_ack && !fetch.branch;
    // inst_valid already masks branch, so a redirect never transfers.
    assign transfer = fetch.inst_valid && fetch.inst_ready;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // Next-state logic: redirect wins, otherwise fill then drain the buffer.
    always_comb begin
        state_d = state_q;
        if (fetch.branch) begin
            state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH: if (fetch.imem_ack) state_d = HOLD;
                HOLD:  if (transfer)       state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // Next pc and buffer contents.
    always_comb begin
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        if (fetch.branch) begin
            pc_d = fetch.targetAddress;
        end else if (ack_take) begin
            inst_d    = fetch.imem_data;
            inst_pc_d = pc_q;
            pc_d      = pc_q + 10'd4;
        end
    end

    // Moore-style outputs, except inst_valid which is masked by branch.
    always_comb begin
        fetch.imem_req   = (state_q == FETCH);
        fetch.imem_addr  = pc_q;
        fetch.inst_valid = (state_q == HOLD) && !fetch.branch;
        fetch.inst       = inst_q;
        fetch.inst_pc    = inst_pc_q;
    end

`ifdef FETCH_REDIRECT_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Saturating count of cycles with branch asserted.
    always_comb begin
        cnt_d = cnt_q;
        if (fetch.branch && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Redirect counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign redirect_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: two fetch stages (RESET_PC 0x000 and 0x3FC) driven with the
// same stimulus and compared every cycle against a buffer-level model, plus
// directed checks for straight-line fetch, backpressure, redirects and wrap.
module tb_pc_fetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_branch;
    logic [9:0]  s_target;
    logic        s_ack;
    logic [31:0] s_data;
    logic        s_ready;

    pc_fetch_if if0 ();
    pc_fetch_if if1 ();

    assign if0.branch        = s_branch;
    assign if0.targetAddress = s_target;
    assign if0.imem_ack      = s_ack;
    assign if0.imem_data     = s_data;
    assign if0.inst_ready    = s_ready;
    assign if1.branch        = s_branch;
    assign if1.targetAddress = s_target;
    assign if1.imem_ack      = s_ack;
    assign if1.imem_data     = s_data;
    assign if1.inst_ready    = s_ready;

`ifdef FETCH_REDIRECT_CNT_EN
    logic [7:0] rcnt0, rcnt1;
    pc_fetch #(.RESET_PC(10'h000)) dut0 (.clk(clk), .rst(rst), .fetch(if0.master), .redirect_cnt(rcnt0));
    pc_fetch #(.RESET_PC(10'h3FC)) dut1 (.clk(clk), .rst(rst), .fetch(if1.master), .redirect_cnt(rcnt1));
`else
    pc_fetch #(.RESET_PC(10'h000)) dut0 (.clk(clk), .rst(rst), .fetch(if0.master));
    pc_fetch #(.RESET_PC(10'h3FC)) dut1 (.clk(clk), .rst(rst), .fetch(if1.master));
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one-entry buffer, plain integer pc.
    int          m_rstpc [2] = '{0, 1020};
    int          m_pc    [2];
    bit          m_full  [2];
    logic [31:0] m_inst  [2];
    int          m_ipc   [2];
    int          m_cnt   [2];

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pc[k] = m_rstpc[k]; m_full[k] = 0; m_inst[k] = 0; m_ipc[k] = 0; m_cnt[k] = 0;
            end else begin
                if (s_branch && m_cnt[k] < 255) m_cnt[k]++;
                if (s_branch) begin
                    m_pc[k] = s_target; m_full[k] = 0;
                end else if (!m_full[k] && s_ack) begin
                    m_inst[k] = s_data; m_ipc[k] = m_pc[k];
                    m_pc[k] = (m_pc[k] + 4) % 1024; m_full[k] = 1;
                end else if (m_full[k] && s_ready) begin
                    m_full[k] = 0;
                end
            end
        end
    endtask

    task automatic model_check();
        logic        req, vld;
        logic [9:0]  addr, ipc;
        logic [31:0] ins;
        for (int k = 0; k < 2; k++) begin
            req  = (k == 0) ? if0.imem_req   : if1.imem_req;
            addr = (k == 0) ? if0.imem_addr  : if1.imem_addr;
            vld  = (k == 0) ? if0.inst_valid : if1.inst_valid;
            ipc  = (k == 0) ? if0.inst_pc    : if1.inst_pc;
            ins  = (k == 0) ? if0.inst       : if1.inst;
            check($sformatf("m%0d_req", k), 32'(req), 32'(!m_full[k]));
            if (!m_full[k]) check($sformatf("m%0d_addr", k), 32'(addr), 32'(m_pc[k]));
            check($sformatf("m%0d_valid", k), 32'(vld), 32'(m_full[k] && !s_branch));
            if (m_full[k]) begin
                check($sformatf("m%0d_inst", k), ins, m_inst[k]);
                check($sformatf("m%0d_inst_pc", k), 32'(ipc), 32'(m_ipc[k]));
            end
`ifdef FETCH_REDIRECT_CNT_EN
            check($sformatf("m%0d_rcnt", k), 32'((k == 0) ? rcnt0 : rcnt1), 32'(m_cnt[k]));
`endif
        end
    endtask

    task automatic drive(input logic rs, input logic b, input logic [9:0] t,
                         input logic a, input logic [31:0] d, input logic r);
        rst = rs; s_branch = b; s_target = t; s_ack = a; s_data = d; s_ready = r;
        #1;
    endtask

    // Called at posedge+2 with inputs applied: check, clock, update model.
    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    logic [31:0] dw [3];

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk); @(posedge clk);
        model_update();
        #1;
        step();

        // Reset state seen in the first cycle after release.
        drive(0, 0, 0, 0, 0, 0);
        check("rst_req",     32'(if0.imem_req), 1);
        check("rst_addr0",   32'(if0.imem_addr), 32'h000);
        check("rst_addr1",   32'(if1.imem_addr), 32'h3FC);
        check("rst_valid",   32'(if0.inst_valid), 0);
        check("rst_inst",    if0.inst, 0);
        check("rst_inst_pc", 32'(if0.inst_pc), 0);

        // Straight-line fetch; dut1 also wraps 0x3FC -> 0x000.
        for (int i = 0; i < 3; i++) begin
            dw[i] = $urandom;
            drive(0, 0, 0, 1, dw[i], 1);
            check("sl_addr0", 32'(if0.imem_addr), 32'(i * 4));
            check("sl_addr1", 32'(if1.imem_addr), 32'((12'h3FC + i * 4) & 12'h3FF));
            step();
            drive(0, 0, 0, 0, 0, 1);
            check("sl_valid",   32'(if0.inst_valid), 1);
            check("sl_inst_pc", 32'(if0.inst_pc), 32'(i * 4));
            check("sl_inst",    if0.inst, dw[i]);
            step();
        end

        // Backpressure for 5 cycles in HOLD.
        drive(0, 0, 0, 1, 32'hA5A5_0001, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            check("bp_valid",   32'(if0.inst_valid), 1);
            check("bp_req",     32'(if0.imem_req), 0);
            check("bp_inst",    if0.inst, 32'hA5A5_0001);
            check("bp_inst_pc", 32'(if0.inst_pc), 32'h00C);
            step();
        end
        drive(0, 0, 0, 0, 0, 1);
        step();

        // Redirect and ack in the same FETCH cycle.
        drive(0, 1, 10'h120, 1, 32'hDEADBEEF, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        check("ra_addr",  32'(if0.imem_addr), 32'h120);
        check("ra_valid", 32'(if0.inst_valid), 0);
        check("ra_req",   32'(if0.imem_req), 1);
        drive(0, 0, 0, 1, 32'h1234_5678, 0);
        step();
        drive(0, 0, 0, 0, 0, 1);
        check("ra_inst_pc", 32'(if0.inst_pc), 32'h120);
        check("ra_no_beef", 32'(if0.inst == 32'hDEADBEEF), 0);
        step();

        // Redirect in HOLD with inst_ready=1.
        drive(0, 0, 0, 1, 32'h0BAD_F00D, 0);
        step();
        drive(0, 1, 10'h120, 0, 0, 1);
        check("rh_valid", 32'(if0.inst_valid), 0);
        step();
        drive(0, 0, 0, 1, 32'h600D_600D, 0);
        check("rh_addr", 32'(if0.imem_addr), 32'h120);
        step();
        drive(0, 0, 0, 0, 0, 1);
        check("rh_inst_pc", 32'(if0.inst_pc), 32'h120);
        check("rh_inst",    if0.inst, 32'h600D_600D);
        step();

        // Reset while requesting, overriding branch and ack.
        drive(1, 1, 10'h055, 1, 32'hFFFF_0000, 1);
        step();
        drive(0, 0, 0, 1, 32'h3FC0_3FC0, 0);
        check("rm_addr1", 32'(if1.imem_addr), 32'h3FC);
        check("rm_addr0", 32'(if0.imem_addr), 32'h000);
        check("rm_valid", 32'(if1.inst_valid), 0);
        step();
        drive(0, 0, 0, 0, 0, 1);
        check("rm_inst_pc1", 32'(if1.inst_pc), 32'h3FC);
        step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                  10'($urandom_range(0, 1023)), 1'($urandom), $urandom, 1'($urandom));
            step();
        end

`ifdef FETCH_REDIRECT_CNT_EN
        drive(1, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 10'($urandom_range(0, 1023)), 1'($urandom), $urandom, 1'($urandom));
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        check("rc_sat0", 32'(rcnt0), 32'hFF);
        check("rc_sat1", 32'(rcnt1), 32'hFF);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
